// File: rtl/ifmap_glb_ctrl_pkg.sv
// Shared types and helpers for the ifmap global-buffer sequencer.
// Holds the FSM encoding, the 64-bit-word lane count and the count clamp.
package ifmap_glb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LANES_PER_WORD = 4;

    function automatic int unsigned clamp_cnt(input int unsigned val, input int unsigned cap);
        return (val > cap) ? cap : val;
    endfunction

endpackage

// File: rtl/ifmap_glb_ctrl_skid_buf.sv
// Two-entry FIFO that absorbs buffer read data so the PE-array handshake can
// stall without losing an element already in flight from port B.
module ifmap_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [1:0]            o_occ,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_ent0;
    logic [DATA_WIDTH-1:0] r_ent1;
    logic [1:0]            r_occ;
    logic                  w_pop;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign o_occ  = r_occ;
    assign o_head = r_ent0;

    // r_ent0 is always the head; entry 1 shifts down on a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_ent0 <= i_push_data;
                    else               r_ent1 <= i_push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_ent0 <= i_push_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifmap_glb_ctrl.sv
// Ifmap global-buffer sequencer: FILL loads 64-bit FIFO words through port A,
// DRAIN streams 16-bit elements from port B to the PE array (valid/ready).
module ifmap_glb_ctrl
    import ifmap_glb_pkg::*;
#(
    parameter  int FIFO_WIDTH = 64,
    parameter  int DATA_WIDTH = 16,
    parameter  int MEM_DEPTH  = 16,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cfg_num_words,
    input  logic [CNT_WIDTH-1:0]  cfg_num_elems,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_re,
    output logic                  glb_we_a,
    output logic                  glb_re_a,
    output logic [ADDR_WIDTH-1:0] glb_addr_a,
    output logic [FIFO_WIDTH-1:0] glb_wdata_a,
    output logic                  glb_we_b,
    output logic                  glb_re_b,
    output logic [ADDR_WIDTH-1:0] glb_addr_b,
    input  logic [DATA_WIDTH-1:0] glb_rdata_b,
    output logic [DATA_WIDTH-1:0] ifmap_data,
    output logic                  ifmap_valid,
    input  logic                  ifmap_ready
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_words;
    logic [CNT_WIDTH-1:0]   r_elems;
    logic [CNT_WIDTH-1:0]   r_wcnt;
    logic [CNT_WIDTH-1:0]   r_rcnt;
    logic                   r_inflight;
    logic [CNT_WIDTH-1:0]   w_words_cfg;
    logic [CNT_WIDTH-1:0]   w_elems_cfg;
    logic                   w_wr;
    logic                   w_fill_last;
    logic                   w_pop;
    logic                   w_issue;
    logic                   w_drain_empty;
    logic [2:0]             w_slots_used;
    logic [1:0]             w_occ;
    logic [DATA_WIDTH-1:0]  w_head;

    assign w_words_cfg = CNT_WIDTH'(clamp_cnt(32'(cfg_num_words), 32'(MEM_DEPTH / LANES_PER_WORD)));
    assign w_elems_cfg = CNT_WIDTH'(clamp_cnt(32'(cfg_num_elems), 32'(MEM_DEPTH)));

    ifmap_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (glb_rdata_b),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    // A slot freed by this cycle's pop can be reused by this cycle's read,
    // which is what sustains one element per cycle with ready held high.
    always_comb begin
        w_wr          = (r_state == FILL) && !fifo_empty;
        w_fill_last   = w_wr && ((r_wcnt + CNT_ONE) == r_words);
        w_pop         = (w_occ != 2'd0) && ifmap_ready;
        w_slots_used  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue       = (r_state == DRAIN) && (r_rcnt < r_elems) && (w_slots_used < 3'd2);
        w_drain_empty = (r_rcnt == r_elems) && !r_inflight && (w_occ == 2'd0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_words_cfg != '0)      w_state_nxt = FILL;
                    else if (w_elems_cfg != '0) w_state_nxt = DRAIN;
                    else                        w_state_nxt = DONE;
                end
            end
            FILL: begin
                if (w_fill_last) w_state_nxt = (r_elems != '0) ? DRAIN : DONE;
            end
            DRAIN: begin
                if (w_drain_empty) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_words    <= '0;
            r_elems    <= '0;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if ((r_state == IDLE) && start) begin
                r_words <= w_words_cfg;
                r_elems <= w_elems_cfg;
                r_wcnt  <= '0;
                r_rcnt  <= '0;
            end
            if (w_wr)    r_wcnt <= r_wcnt + CNT_ONE;
            if (w_issue) r_rcnt <= r_rcnt + CNT_ONE;
        end
    end

    // Port A addresses whole words, so the lane bits are always zero.
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign fifo_re     = w_wr;
    assign glb_we_a    = w_wr;
    assign glb_re_a    = 1'b0;
    assign glb_addr_a  = (r_state == FILL) ? {r_wcnt[ADDR_WIDTH-3:0], 2'b00} : '0;
    assign glb_wdata_a = (r_state == FILL) ? fifo_rdata : '0;
    assign glb_we_b    = 1'b0;
    assign glb_re_b    = w_issue;
    assign glb_addr_b  = w_issue ? r_rcnt[ADDR_WIDTH-1:0] : '0;
    assign ifmap_data  = w_head;
    assign ifmap_valid = (w_occ != 2'd0);

endmodule

// File: tb/tb_ifmap_glb_ctrl.sv
// Directed bench for ifmap_glb_ctrl with a FIFO model, a buffer model and a
// scoreboard of expected ifmap elements.
module tb_ifmap_glb_ctrl;

    localparam int FW = 64;
    localparam int DW = 16;
    localparam int MD = 16;
    localparam int AW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] cfg_num_words;
    logic [CW-1:0] cfg_num_elems;
    logic          busy;
    logic          done;
    logic          fifo_empty;
    logic [FW-1:0] fifo_rdata;
    logic          fifo_re;
    logic          glb_we_a;
    logic          glb_re_a;
    logic [AW-1:0] glb_addr_a;
    logic [FW-1:0] glb_wdata_a;
    logic          glb_we_b;
    logic          glb_re_b;
    logic [AW-1:0] glb_addr_b;
    logic [DW-1:0] glb_rdata_b;
    logic [DW-1:0] ifmap_data;
    logic          ifmap_valid;
    logic          ifmap_ready;

    ifmap_glb_ctrl #(.FIFO_WIDTH(FW), .DATA_WIDTH(DW), .MEM_DEPTH(MD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_num_words(cfg_num_words), .cfg_num_elems(cfg_num_elems),
        .busy(busy), .done(done),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_re(fifo_re),
        .glb_we_a(glb_we_a), .glb_re_a(glb_re_a), .glb_addr_a(glb_addr_a),
        .glb_wdata_a(glb_wdata_a), .glb_we_b(glb_we_b), .glb_re_b(glb_re_b),
        .glb_addr_b(glb_addr_b), .glb_rdata_b(glb_rdata_b),
        .ifmap_data(ifmap_data), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int words;
        int elems;
        int fifo_n;
        bit ready_tog;
        bit gap;
        int restart_at;
        int exp_writes;
        int exp_out;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // models and monitor state
    logic [FW-1:0] fifo_q[$];
    logic [DW-1:0] mem[MD];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rd_next;
    logic [DW-1:0] prev_d;
    logic [AW-1:0] first_re_addr;
    bit  pop_req, rd_req, prev_v, prev_r, force_empty, gap_en, gap_done, ready_tog;
    int  cyc = 0;
    int  gap_left, pat_idx;
    int  first_wr, last_wr, first_re, first_valid, start_cyc, done_cyc;
    int  rd_issued, done_cnt, fifo_re_cnt;
    int  gap_viol, seq_viol, occ_viol, hold_viol, excl_viol, busy_viol;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic update_fifo_pins();
        fifo_empty = force_empty || (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '1;
    endtask

    // advance one clock; inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (pop_req) begin
            if (fifo_q.size() != 0) fifo_q.delete(0);
            pop_req = 1'b0;
        end
        if (gap_en && !gap_done && wr_addr_q.size() == 2) begin
            gap_left = 3;
            gap_done = 1'b1;
        end
        force_empty = (gap_left > 0);
        if (gap_left > 0) gap_left--;
        update_fifo_pins();
        ifmap_ready = ready_tog ? ((pat_idx % 4 == 0) || (pat_idx % 4 == 3)) : 1'b1;
        pat_idx++;
        if (rd_req) begin
            glb_rdata_b = rd_next;
            rd_req = 1'b0;
        end else begin
            glb_rdata_b = 16'hBAD0;
        end
    endtask

    task automatic clear_stats();
        wr_addr_q.delete();
        out_q.delete();
        exp_q.delete();
        first_wr = -1; last_wr = -1; first_re = -1; first_valid = -1;
        start_cyc = -1; done_cyc = -1; first_re_addr = '1;
        rd_issued = 0; done_cnt = 0; fifo_re_cnt = 0;
        gap_viol = 0; seq_viol = 0; occ_viol = 0; hold_viol = 0; excl_viol = 0; busy_viol = 0;
        gap_left = 0; gap_done = 1'b0; force_empty = 1'b0; pat_idx = 0;
        prev_v = 1'b0; prev_r = 1'b0;
    endtask

    task automatic load_fifo(input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++)
            fifo_q.push_back(64'h0004_0003_0002_0001 + 64'(i) * 64'h0004_0004_0004_0004);
        update_fifo_pins();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_v <= 1'b0;
        end else begin
            if (rd_issued - out_q.size() > 2) occ_viol++;
            if (prev_v && !prev_r && (!ifmap_valid || ifmap_data !== prev_d)) hold_viol++;
            if (start && start_cyc < 0) start_cyc = cyc;
            if (fifo_re) fifo_re_cnt++;
            if (fifo_re !== glb_we_a) excl_viol++;
            if ((glb_we_a && glb_re_b) || glb_re_a || glb_we_b) excl_viol++;
            if (glb_we_a) begin
                if (force_empty) gap_viol++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                wr_addr_q.push_back(glb_addr_a);
                for (int k = 0; k < 4; k++) mem[int'(glb_addr_a) + k] = glb_wdata_a[16*k +: 16];
                pop_req = 1'b1;
            end
            if (glb_re_b) begin
                if (first_re < 0) begin
                    first_re = cyc;
                    first_re_addr = glb_addr_b;
                end
                if (int'(glb_addr_b) != (rd_issued % MD)) seq_viol++;
                rd_next = mem[glb_addr_b];
                rd_req = 1'b1;
                rd_issued++;
            end
            if (ifmap_valid && first_valid < 0) first_valid = cyc;
            if (ifmap_valid && ifmap_ready) out_q.push_back(ifmap_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (!busy) busy_viol++;
            end
            prev_v = ifmap_valid;
            prev_r = ifmap_ready;
            prev_d = ifmap_data;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        clear_stats();
        ready_tog = v.ready_tog;
        gap_en = v.gap;
        load_fifo(v.fifo_n);
        for (int e = 1; e <= v.exp_out; e++) exp_q.push_back(DW'(e));
        cfg_num_words = CW'(v.words);
        cfg_num_elems = CW'(v.elems);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            if (i == v.restart_at) begin
                cfg_num_words = CW'(1);
                cfg_num_elems = CW'(2);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        chk({t, "_done_count"}, done_cnt, 1);
        chk({t, "_busy_idle"}, int'(busy), 0);
        chk({t, "_writes"}, wr_addr_q.size(), v.exp_writes);
        for (int i = 0; i < wr_addr_q.size(); i++)
            chk($sformatf("%s_waddr%0d", t, i), int'(wr_addr_q[i]), 4 * i);
        chk({t, "_fifo_left"}, fifo_q.size(), v.fifo_n - v.exp_writes);
        chk({t, "_out_count"}, out_q.size(), v.exp_out);
        for (int i = 0; out_q.size() != 0 && exp_q.size() != 0; i++)
            chk($sformatf("%s_data%0d", t, i), int'(out_q.pop_front()), int'(exp_q.pop_front()));
        chk({t, "_gap_strobe"}, gap_viol, 0);
        chk({t, "_raddr_seq"}, seq_viol, 0);
        chk({t, "_occupancy"}, occ_viol, 0);
        chk({t, "_hold"}, hold_viol, 0);
        chk({t, "_port_excl"}, excl_viol, 0);
        chk({t, "_done_busy"}, busy_viol, 0);
        if (v.exp_writes > 0)
            chk({t, "_wr_span"}, last_wr - first_wr, v.exp_writes - 1 + (v.gap ? 3 : 0));
        if (v.exp_out > 0) begin
            chk({t, "_first_raddr"}, int'(first_re_addr), 0);
            chk({t, "_first_re"}, first_re, (v.exp_writes > 0) ? last_wr + 1 : start_cyc + 1);
            chk({t, "_first_valid"}, first_valid, first_re + 2);
        end else begin
            chk({t, "_no_reads"}, rd_issued, 0);
        end
        if (v.exp_writes == 0)
            chk({t, "_no_fifo_re"}, fifo_re_cnt, 0);
        if (v.exp_writes == 0 && v.exp_out == 0)
            chk({t, "_done_latency"}, done_cyc - start_cyc, 1);
    endtask

    vec_t vecs[8];
    vec_t v_after_rst;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // words, elems, fifo_n, ready_tog, gap, restart_at, exp_writes, exp_out
        vecs[0] = '{4, 16, 4, 1'b0, 1'b0, -1, 4, 16};
        vecs[1] = '{4, 16, 4, 1'b0, 1'b1, -1, 4, 16};
        vecs[2] = '{4, 16, 4, 1'b1, 1'b0, -1, 4, 16};
        vecs[3] = '{0,  0, 0, 1'b0, 1'b0, -1, 0,  0};
        vecs[4] = '{7, 16, 7, 1'b0, 1'b0,  5, 4, 16};
        vecs[5] = '{2,  5, 2, 1'b1, 1'b0, -1, 2,  5};
        vecs[6] = '{1, 20, 1, 1'b0, 1'b0, -1, 1, 16};
        vecs[7] = '{3,  0, 3, 1'b0, 1'b0, -1, 3,  0};
        v_after_rst = '{0, 16, 0, 1'b0, 1'b0, -1, 0, 16};

        rst_n = 1'b0; start = 1'b0; cfg_num_words = '0; cfg_num_elems = '0;
        ifmap_ready = 1'b1; glb_rdata_b = '0; ready_tog = 1'b0; gap_en = 1'b0;
        pop_req = 1'b0; rd_req = 1'b0; rd_next = '0; prev_d = '0;
        for (int i = 0; i < MD; i++) mem[i] = '0;
        clear_stats();
        load_fifo(2);
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        chk_wide("reset_outputs", {32'b0, busy, done, fifo_re, glb_we_a, glb_re_a, glb_addr_a,
                 glb_wdata_a, glb_we_b, glb_re_b, glb_addr_b, ifmap_data, ifmap_valid}, 128'b0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // reset in the middle of DRAIN, then restart without a fill
        clear_stats();
        ready_tog = 1'b0;
        gap_en = 1'b0;
        load_fifo(4);
        cfg_num_words = CW'(4);
        cfg_num_elems = CW'(16);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200 && out_q.size() < 5; i++) step();
        chk("mid_rst_delivered", out_q.size(), 5);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk_wide("mid_rst_outputs", {32'b0, busy, done, fifo_re, glb_we_a, glb_re_a, glb_addr_a,
                 glb_wdata_a, glb_we_b, glb_re_b, glb_addr_b, ifmap_data, ifmap_valid}, 128'b0);
        rst_n = 1'b1;
        step();
        step();
        run_vec(v_after_rst, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
